ps2_to_xt_fifo: RTL
===================

// Module: ps2_to_xt_fifo
// PURPOSE
//  Parametrised PS/2 scan-code-set-2 -> XT set-1 translator with a FIFO, between KFPS2KB and KF8255/KF8259.
//  Decodes F0 (break) and E0 (extended) prefixes and translates each code through the set-2->set-1 table.
//  Queues the XT bytes so several keys can arrive before the CPU reads the first one.
//  Raises irq whenever a byte is waiting; KF8255 pops one byte per clear pulse.
// PARAMETERS
//  FIFO_DEPTH  8      entries, power of 2, >=4
//  ERROR_CODE  8'hFF  byte queued on overflow (XT buffer-error code)
// PORTS
//  clock              in   1  system clock; all state updates on negedge
//  reset              in   1  asynchronous, active-high
//  ps2_keycode        in   8  received PS/2 byte, valid while ps2_recive_flag=1
//  ps2_recive_flag    in   1  KFPS2KB byte-ready flag (level)
//  ps2_clear_keycode  out  1  one-cycle ack to KFPS2KB
//  xt_clear_keycode   in   1  KF8255 PB7 clear/acknowledge (level)
//  xt_keycode         out  8  FIFO head byte to KF8255 port A
//  irq                out  1  byte available, to KF8259 IR1
//  fifo_count         out  $clog2(FIFO_DEPTH)+1  entries held
//  overflow           out  1  sticky: at least one sequence dropped
// BEHAVIOUR
//  Reset: ps2_clear_keycode=0, xt_keycode=00, irq=0, fifo_count=0, overflow=0, decoder IDLE.
//  Reset mid-operation discards the FIFO and any partial prefix sequence.
//  Receive edge: ps2_recive_flag=1 while the previous-cycle sample=0. On the same negedge the
//   byte is decoded; ps2_clear_keycode=1 for exactly the next cycle.
//  Decoder FSM:
//   IDLE: E0 -> EXT; F0 -> BRK; other code -> push table(code); stay IDLE
//   EXT: F0 -> EXT_BRK; other code -> push [E0 if enabled], table(code); go IDLE
//   BRK: code -> push table(code)|80; go IDLE
//   EXT_BRK: code -> push [E0], table(code)|80; go IDLE
//   E0 or F0 arriving in BRK or EXT_BRK: drop the sequence, push nothing, go IDLE.
//  Table: standard set 2 -> set 1 mapping (00->FF, 01->43, 76->01, 83->41, ...).
//   Codes >=0x84 pass through unchanged.
//  Multi-byte push: the pair E0,code is written on two consecutive negedges;
//   a pending-write register holds the second byte.
//  Space rule: 1 entry is reserved for ERROR_CODE.
//   Normal push needs count <= DEPTH-1-n, with n = bytes in the sequence.
//   Otherwise: drop the whole sequence and set overflow=1.
//   Also push ERROR_CODE if count<DEPTH and the last written byte != ERROR_CODE.
//  overflow clears when the FIFO drains to 0 (with irq low); otherwise only on reset.
//  Read side: pop on rising edge of xt_clear_keycode.
//   While xt_clear_keycode=1: irq=0 and xt_keycode=00.
//   The negedge after it falls: xt_keycode=head and irq=(count!=0).
//  Latency: write at negedge k into an empty FIFO -> xt_keycode/irq valid at negedge k+1.
//  Simultaneous push and pop: both happen; count unchanged; pointers wrap modulo FIFO_DEPTH.
//  A push while full is impossible by the space rule; a pop while empty is ignored.
// CONFIGURATION
//  PS2XT_E0_PREFIX_EN defined:
//   E0 is forwarded as an XT E0 byte before extended codes (2-byte sequences).
//  Not defined:
//   E0 is consumed and dropped; extended keys emit only the translated code (n=1).
//   The EXT and EXT_BRK states still exist.
// TESTING
//  1C; then F0,1C; with reads between -> 1E, then 9E; irq low after each clear.
//   ps2_clear_keycode pulses 3 times.
//  E0,75 then E0,F0,75 -> EN: E0,48,E0,C8. Without EN: 48,C8.
//  DEPTH=8, no reads, 10 single-byte makes:
//   FIFO = 7 codes + FF, overflow=1, fifo_count=8.
//   Drain 8 -> overflow=0.
//  Push on the same negedge as a clear-edge pop with count=3 -> count stays 3, order preserved.
//  F0,E0,1C -> only 1E queued (F0,E0 sequence dropped).
//  Assert reset mid-sequence after F0, then send 1C -> 1E (not 9E); all outputs were 0 during reset.

Source files
------------

// File: rtl/ps2_to_xt_fifo_if.sv
// Signal bundle between the PS/2 receiver, the set-2 -> set-1 translator FIFO and the XT port/interrupt side.
interface ps2_to_xt_fifo_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // PS/2 side: ps2_keycode is valid while ps2_recive_flag is high; the rising edge of the flag
    // is the transfer, ps2_clear_keycode acks it for one cycle. XT side: xt_keycode is valid while
    // irq is high; the rising edge of xt_clear_keycode consumes it.
    logic [7:0]    ps2_keycode;
    logic          ps2_recive_flag;
    logic          ps2_clear_keycode;
    logic          xt_clear_keycode;
    logic [7:0]    xt_keycode;
    logic          irq;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic [1:0]    decoder_state;

    modport master (
        output ps2_keycode, ps2_recive_flag, xt_clear_keycode,
        input  ps2_clear_keycode, xt_keycode, irq, fifo_count, overflow, decoder_state
    );

    modport slave (
        input  ps2_keycode, ps2_recive_flag, xt_clear_keycode,
        output ps2_clear_keycode, xt_keycode, irq, fifo_count, overflow, decoder_state
    );
endinterface

// File: rtl/ps2_to_xt_fifo.sv
// PS/2 set-2 to XT set-1 translator with an output FIFO, all state on the falling clock edge.
// Define PS2XT_E0_PREFIX_EN to forward E0 ahead of extended codes; otherwise E0 is swallowed.
module ps2_to_xt_fifo #(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] ERROR_CODE = 8'hFF
) (
    input logic             clock,
    input logic             reset,
    ps2_to_xt_fifo_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [7:0] XLAT [0:131] = '{
        8'hff, 8'h43, 8'h41, 8'h3f, 8'h3d, 8'h3b, 8'h3c, 8'h58, 8'h64, 8'h44, 8'h42, 8'h40, 8'h3e, 8'h0f, 8'h29, 8'h59,
        8'h65, 8'h38, 8'h2a, 8'h70, 8'h1d, 8'h10, 8'h02, 8'h5a, 8'h66, 8'h71, 8'h2c, 8'h1f, 8'h1e, 8'h11, 8'h03, 8'h5b,
        8'h67, 8'h2e, 8'h2d, 8'h20, 8'h12, 8'h05, 8'h04, 8'h5c, 8'h68, 8'h39, 8'h2f, 8'h21, 8'h14, 8'h13, 8'h06, 8'h5d,
        8'h69, 8'h31, 8'h30, 8'h23, 8'h22, 8'h15, 8'h07, 8'h5e, 8'h6a, 8'h72, 8'h32, 8'h24, 8'h16, 8'h08, 8'h09, 8'h5f,
        8'h6b, 8'h33, 8'h25, 8'h17, 8'h18, 8'h0b, 8'h0a, 8'h60, 8'h6c, 8'h34, 8'h35, 8'h26, 8'h27, 8'h19, 8'h0c, 8'h61,
        8'h6d, 8'h73, 8'h28, 8'h74, 8'h1a, 8'h0d, 8'h62, 8'h6e, 8'h3a, 8'h36, 8'h1c, 8'h1b, 8'h75, 8'h2b, 8'h63, 8'h76,
        8'h55, 8'h56, 8'h77, 8'h78, 8'h79, 8'h7a, 8'h0e, 8'h7b, 8'h7c, 8'h4f, 8'h7d, 8'h4b, 8'h47, 8'h7e, 8'h7f, 8'h6f,
        8'h52, 8'h53, 8'h50, 8'h4c, 8'h4d, 8'h48, 8'h01, 8'h45, 8'h57, 8'h4e, 8'h51, 8'h4a, 8'h37, 8'h49, 8'h46, 8'h54,
        8'h80, 8'h81, 8'h82, 8'h41
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t        state, state_next;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          flag_q, clear_q;
    logic          pend_valid;
    logic [7:0]    pend_byte, last_wr;
    logic          ack_q, irq_q, ovf_q;
    logic [7:0]    key_q;

    logic          rx_edge, pop, is_e0, is_f0;
    logic          seq_valid, seq_two, room_ok, ovf_set, err_push, wr_en;
    logic [7:0]    code, seq_first, seq_second, wr_data;

    function automatic logic [7:0] xlat(input logic [7:0] c);
        return (c < 8'h84) ? XLAT[c] : c;
    endfunction

    always_comb begin
        rx_edge    = bus.ps2_recive_flag & ~flag_q;
        pop        = bus.xt_clear_keycode & ~clear_q & (count != '0);
        is_e0      = (bus.ps2_keycode == 8'hE0);
        is_f0      = (bus.ps2_keycode == 8'hF0);
        code       = xlat(bus.ps2_keycode);
        state_next = state;
        seq_valid  = 1'b0;
        seq_two    = 1'b0;
        seq_first  = code;
        seq_second = code;
        if (rx_edge) begin
            case (state)
                IDLE: begin
                    if (is_e0)      state_next = EXT;
                    else if (is_f0) state_next = BRK;
                    else            seq_valid  = 1'b1;
                end
                EXT: begin
                    if (is_f0) begin
                        state_next = EXT_BRK;
                    end else begin
                        state_next = IDLE;
                        seq_valid  = 1'b1;
`ifdef PS2XT_E0_PREFIX_EN
                        seq_two    = 1'b1;
                        seq_first  = 8'hE0;
`endif
                    end
                end
                BRK: begin
                    state_next = IDLE;
                    seq_valid  = ~(is_e0 | is_f0);
                    seq_first  = code | 8'h80;
                end
                EXT_BRK: begin
                    state_next = IDLE;
                    seq_valid  = ~(is_e0 | is_f0);
                    seq_first  = code | 8'h80;
                    seq_second = code | 8'h80;
`ifdef PS2XT_E0_PREFIX_EN
                    seq_two    = 1'b1;
                    seq_first  = 8'hE0;
`endif
                end
                default: state_next = IDLE;
            endcase
        end
        // One slot always stays free so an overflow can still be reported with ERROR_CODE.
        room_ok  = (int'(count) + (seq_two ? 2 : 1)) <= (FIFO_DEPTH - 1);
        ovf_set  = seq_valid & ~room_ok;
        err_push = ovf_set & (int'(count) < FIFO_DEPTH) & (last_wr != ERROR_CODE);
        wr_en    = pend_valid | (seq_valid & room_ok) | err_push;
        wr_data  = pend_valid ? pend_byte : (ovf_set ? ERROR_CODE : seq_first);
    end

    always_ff @(negedge clock) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            flag_q     <= 1'b0;
            clear_q    <= 1'b0;
            pend_valid <= 1'b0;
            pend_byte  <= 8'h00;
            last_wr    <= 8'h00;
            ack_q      <= 1'b0;
            irq_q      <= 1'b0;
            key_q      <= 8'h00;
            ovf_q      <= 1'b0;
        end else begin
            flag_q  <= bus.ps2_recive_flag;
            clear_q <= bus.xt_clear_keycode;
            ack_q   <= rx_edge;
            state   <= state_next;
            if (wr_en) begin
                wr_ptr  <= wr_ptr + AW'(1);
                last_wr <= wr_data;
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count      <= count + CW'(wr_en) - CW'(pop);
            // Second byte of an E0-prefixed pair lands on the following edge.
            pend_valid <= ~pend_valid & seq_valid & room_ok & seq_two;
            pend_byte  <= seq_second;
            if (bus.xt_clear_keycode) begin
                irq_q <= 1'b0;
                key_q <= 8'h00;
            end else begin
                irq_q <= (count != '0);
                key_q <= (count != '0) ? mem[rd_ptr] : 8'h00;
            end
            if (ovf_set)                          ovf_q <= 1'b1;
            else if ((count == '0) && !irq_q)     ovf_q <= 1'b0;
        end
    end

    assign bus.ps2_clear_keycode = ack_q;
    assign bus.xt_keycode        = key_q;
    assign bus.irq               = irq_q;
    assign bus.fifo_count        = count;
    assign bus.overflow          = ovf_q;
    assign bus.decoder_state     = state;
endmodule
